// File: rtl/adc_ctrl_pkg.sv
// Shared encodings for the ADC conversion sequencer: FSM state codes and
// arbiter grant identifiers.
package adc_ctrl_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_POWERUP = 3'd1;
   localparam logic [2:0] S_SETUP   = 3'd2;
   localparam logic [2:0] S_CONV    = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_CAPTURE = 3'd5;

   localparam logic GRANT_CPU  = 1'b0;
   localparam logic GRANT_SCAN = 1'b1;

endpackage

// File: rtl/adc_scan_timer.sv
// Periodic scan trigger: reloading down-counter, pending/overrun flags and
// mask-driven channel pointer that picks the next enabled input.
module adc_scan_timer
   import adc_ctrl_pkg::*;
#(
   parameter int SRC_W = 2,
   parameter int PER_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  scan_en,
   input  logic [PER_W-1:0]      scan_period,
   input  logic [2**SRC_W-1:0]   scan_mask,
   input  logic                  take,
   output logic                  pending,
   output logic                  ovr,
   output logic [SRC_W-1:0]      chan
);

   localparam int NCH = 2**SRC_W;

   logic [PER_W-1:0] cnt;
   logic [PER_W-1:0] reload;
   logic [SRC_W-1:0] ptr;
   logic [SRC_W-1:0] idx;
   logic             active;
   logic             fire;
   logic             found;

   // A period of 0 behaves like 1: the counter reloads to 0 and fires every cycle.
   assign reload = (scan_period == '0) ? '0 : scan_period - PER_W'(1);
   assign active = scan_en && (scan_mask != '0);
   assign fire   = active && (cnt == '0);

   always_comb begin
      chan  = ptr;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         idx = ptr + SRC_W'(i);
         if (!found && scan_mask[idx]) begin
            chan  = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         pending <= 1'b0;
         ovr     <= 1'b0;
         ptr     <= '0;
      end else begin
         if (!active || fire) begin
            cnt <= reload;
         end else begin
            cnt <= cnt - PER_W'(1);
         end

         if (!scan_en) begin
            pending <= 1'b0;
            ovr     <= 1'b0;
         end else begin
            // No queueing: a second trigger while one is still waiting is only flagged.
            if (fire && pending && !take) begin
               ovr <= 1'b1;
            end
            pending <= active && ((pending && !take) || fire);
         end

         if (take) begin
            ptr <= chan + SRC_W'(1);
         end
      end
   end

endmodule

// File: rtl/adc_conv_sequencer.sv
// Owns one ADC macro and shares it between a CPU single-shot requester and the
// periodic scan engine; sequences power-up, select, convert, wait and capture.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  IDLE      | no job; grants pending work, drops adc_ena when nothing pending
//  POWERUP   | adc_ena high, settling before the first convert
//  SETUP     | input mux driven with the granted source
//  CONV      | adc_convert pulse, timeout counter cleared
//  WAIT      | waiting for synchronised done edge or timeout
//  CAPTURE   | latch result (0 on timeout), pulse ack/valid on exit
module adc_conv_sequencer
   import adc_ctrl_pkg::*;
#(
   parameter int DATA_W      = 10,
   parameter int SRC_W       = 2,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1024,
   parameter int PER_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic [SRC_W-1:0]      cpu_src,
   output logic                  cpu_ack,
   output logic [DATA_W-1:0]     cpu_data,
   output logic                  cpu_err,
   input  logic                  scan_en,
   input  logic [PER_W-1:0]      scan_period,
   input  logic [2**SRC_W-1:0]   scan_mask,
   output logic                  scan_valid,
   output logic [SRC_W-1:0]      scan_chan,
   output logic [DATA_W-1:0]     scan_data,
   output logic                  scan_ovr,
   output logic                  adc_ena,
   output logic                  adc_convert,
   output logic [SRC_W-1:0]      adc_inputsrc,
   input  logic                  adc_done,
   input  logic [DATA_W-1:0]     adc_data,
   output logic                  busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + SETTLE_CYC + 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             grant_q;
   logic             err_q;
   logic             done_s1, done_s2, done_s3;
   logic             done_edge;
   logic             scan_pending;
   logic             scan_take;
   logic [SRC_W-1:0] scan_next;
   logic             cpu_pend;
   logic             pick;
   logic             grant_now;

   adc_scan_timer #(
      .SRC_W (SRC_W),
      .PER_W (PER_W)
   ) u_scan_timer (
      .clk         (clk),
      .reset       (reset),
      .scan_en     (scan_en),
      .scan_period (scan_period),
      .scan_mask   (scan_mask),
      .take        (scan_take),
      .pending     (scan_pending),
      .ovr         (scan_ovr),
      .chan        (scan_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         done_s1 <= 1'b0;
         done_s2 <= 1'b0;
         done_s3 <= 1'b0;
      end else begin
         done_s1 <= adc_done;
         done_s2 <= done_s1;
         done_s3 <= done_s2;
      end
   end

   assign done_edge = done_s2 & ~done_s3;
   assign busy      = (state != S_IDLE);

   // The requester is still holding cpu_req during its ack cycle; that is not a new request.
   always_comb begin
      cpu_pend = cpu_req & ~cpu_ack;
      if (cpu_pend && scan_pending) begin
         pick = ~last_grant;
      end else if (cpu_pend) begin
         pick = GRANT_CPU;
      end else begin
         pick = GRANT_SCAN;
      end
      grant_now = (state == S_IDLE) && (cpu_pend || scan_pending);
      scan_take = grant_now && (pick == GRANT_SCAN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         last_grant   <= GRANT_SCAN;
         grant_q      <= GRANT_CPU;
         err_q        <= 1'b0;
         adc_ena      <= 1'b0;
         adc_convert  <= 1'b0;
         adc_inputsrc <= '0;
         cpu_ack      <= 1'b0;
         cpu_err      <= 1'b0;
         cpu_data     <= '0;
         scan_valid   <= 1'b0;
         scan_chan    <= '0;
         scan_data    <= '0;
      end else begin
         adc_convert <= 1'b0;
         cpu_ack     <= 1'b0;
         cpu_err     <= 1'b0;
         scan_valid  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (grant_now) begin
                  grant_q      <= pick;
                  last_grant   <= pick;
                  adc_inputsrc <= (pick == GRANT_SCAN) ? scan_next : cpu_src;
                  if (adc_ena) begin
                     state <= S_SETUP;
                  end else begin
                     // POWERUP + SETUP together span SETTLE_CYC cycles before convert.
                     adc_ena <= 1'b1;
                     cnt     <= CNT_W'(SETTLE_CYC - 2);
                     state   <= S_POWERUP;
                  end
               end else begin
                  adc_ena <= 1'b0;
               end
            end

            S_POWERUP: begin
               if (cnt == '0) begin
                  state <= S_SETUP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            S_SETUP: begin
               adc_convert <= 1'b1;
               state       <= S_CONV;
            end

            S_CONV: begin
               cnt   <= '0;
               state <= S_WAIT;
            end

            S_WAIT: begin
               if (done_edge) begin
                  err_q <= 1'b0;
                  state <= S_CAPTURE;
               end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  err_q <= 1'b1;
                  state <= S_CAPTURE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_CAPTURE: begin
               if (grant_q == GRANT_CPU) begin
                  cpu_ack  <= 1'b1;
                  cpu_err  <= err_q;
                  cpu_data <= err_q ? '0 : adc_data;
               end else begin
                  scan_valid <= 1'b1;
                  scan_chan  <= adc_inputsrc;
                  scan_data  <= err_q ? '0 : adc_data;
               end
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer with a behavioural ADC macro that
// raises done a programmable number of cycles after each convert pulse.
module tb_adc_conv_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cpu_req;
   logic [1:0] cpu_src;
   logic       cpu_ack;
   logic [9:0] cpu_data;
   logic       cpu_err;
   logic       scan_en;
   logic [15:0] scan_period;
   logic [3:0] scan_mask;
   logic       scan_valid;
   logic [1:0] scan_chan;
   logic [9:0] scan_data;
   logic       scan_ovr;
   logic       adc_ena;
   logic       adc_convert;
   logic [1:0] adc_inputsrc;
   logic       adc_done = 1'b0;
   logic [9:0] adc_data = '0;
   logic       busy;

   always #5 clk = ~clk;

   adc_conv_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_req      (cpu_req),
      .cpu_src      (cpu_src),
      .cpu_ack      (cpu_ack),
      .cpu_data     (cpu_data),
      .cpu_err      (cpu_err),
      .scan_en      (scan_en),
      .scan_period  (scan_period),
      .scan_mask    (scan_mask),
      .scan_valid   (scan_valid),
      .scan_chan    (scan_chan),
      .scan_data    (scan_data),
      .scan_ovr     (scan_ovr),
      .adc_ena      (adc_ena),
      .adc_convert  (adc_convert),
      .adc_inputsrc (adc_inputsrc),
      .adc_done     (adc_done),
      .adc_data     (adc_data),
      .busy         (busy)
   );

   // ADC macro model: done_delay = 0 means the macro never answers.
   int         done_delay = 20;
   logic [9:0] model_data = '0;
   int         mctr = 0;
   logic       armed = 1'b0;

   always @(posedge clk) begin
      if (adc_convert) begin
         adc_done <= 1'b0;
         armed    <= (done_delay > 0);
         mctr     <= done_delay;
      end else if (armed) begin
         if (mctr <= 1) begin
            adc_done <= 1'b1;
            adc_data <= model_data;
            armed    <= 1'b0;
         end else begin
            mctr <= mctr - 1;
         end
      end
   end

   int vec = 0;
   int errs = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Issue one CPU request and observe it to completion (or budget expiry).
   task automatic cpu_job(input logic [1:0] src, input int budget,
                          output int t_ena, output int t_conv, output int t_ack,
                          output int nconv, output logic [1:0] src_conv,
                          output logic [9:0] data, output logic err);
      t_ena = -1; t_conv = -1; t_ack = -1; nconv = 0;
      src_conv = '0; data = '0; err = 1'b0;
      cpu_src = src;
      cpu_req = 1'b1;
      for (int c = 0; c < budget && t_ack < 0; c++) begin
         tick(1);
         if (adc_ena && t_ena < 0) t_ena = c;
         if (adc_convert) begin
            nconv++;
            if (t_conv < 0) begin
               t_conv   = c;
               src_conv = adc_inputsrc;
            end
         end
         if (cpu_ack) begin
            t_ack   = c;
            data    = cpu_data;
            err     = cpu_err;
            cpu_req = 1'b0;
         end
      end
      cpu_req = 1'b0;
   endtask

   int         t_ena, t_conv, t_ack, nconv;
   logic [1:0] src_conv;
   logic [9:0] got_data;
   logic       got_err;
   int         nv;
   int         t_v [4];
   int         ch_v [4];
   int         d_v [4];
   int         kind [4];
   logic       ena_mid;
   logic       seen;
   int         acks_in_reset;

   initial begin
      cpu_req = 1'b0; cpu_src = '0;
      scan_en = 1'b0; scan_period = '0; scan_mask = '0;
      tick(3);
      reset = 1'b0;
      tick(1);

      // reset state
      chk("rst_busy",    busy, 0);
      chk("rst_ena",     adc_ena, 0);
      chk("rst_convert", adc_convert, 0);
      chk("rst_ack",     cpu_ack, 0);
      chk("rst_data",    cpu_data, 0);
      chk("rst_valid",   scan_valid, 0);
      chk("rst_ovr",     scan_ovr, 0);
      chk("rst_src",     adc_inputsrc, 0);

      // 1: cold CPU conversion, done 20 cycles after convert
      model_data = 10'h2A5; done_delay = 20;
      cpu_job(2'd2, 200, t_ena, t_conv, t_ack, nconv, src_conv, got_data, got_err);
      chk("t1_ack_seen",  t_ack >= 0, 1);
      chk("t1_settle",    t_conv - t_ena, 16);
      chk("t1_src",       src_conv, 2);
      chk("t1_conv_w",    nconv, 1);
      // 20 macro + 1 model sample + 2 sync + 1 WAIT exit + 1 CAPTURE
      chk("t1_latency",   t_ack - t_conv, 25);
      chk("t1_data",      got_data, 10'h2A5);
      chk("t1_err",       got_err, 0);
      tick(1);
      chk("t1_ena_off",   adc_ena, 0);
      chk("t1_idle",      busy, 0);

      // 4: macro never answers -> timeout
      done_delay = 0;
      cpu_job(2'd1, 1300, t_ena, t_conv, t_ack, nconv, src_conv, got_data, got_err);
      chk("t4_ack_seen",  t_ack >= 0, 1);
      chk("t4_latency",   t_ack - t_conv, 1026);
      chk("t4_err",       got_err, 1);
      chk("t4_data",      got_data, 0);
      tick(1);
      chk("t4_idle",      busy, 0);

      // 2: periodic scan over channels 1 and 3
      scan_period = 16'd100; scan_mask = 4'b1010;
      model_data = 10'h155; done_delay = 20;
      tick(2);
      scan_en = 1'b1;
      nv = 0; ena_mid = 1'b0;
      for (int c = 0; c < 700 && nv < 4; c++) begin
         tick(1);
         if (nv > 0 && c == t_v[nv-1] + 30) ena_mid = ena_mid | adc_ena;
         if (scan_valid) begin
            t_v[nv]  = c;
            ch_v[nv] = int'(scan_chan);
            d_v[nv]  = int'(scan_data);
            nv++;
         end
      end
      scan_en = 1'b0;
      chk("t2_events", nv, 4);
      chk("t2_chan0", ch_v[0], 1);
      chk("t2_chan1", ch_v[1], 3);
      chk("t2_chan2", ch_v[2], 1);
      chk("t2_chan3", ch_v[3], 3);
      chk("t2_data0", d_v[0], 10'h155);
      chk("t2_data3", d_v[3], 10'h155);
      for (int i = 1; i < 4; i++) chk("t2_spacing", t_v[i] - t_v[i-1], 100);
      chk("t2_ena_gap", ena_mid, 0);
      tick(5);

      // 5: overrun with short period and long conversions
      scan_period = 16'd10; scan_mask = 4'b0001; done_delay = 40;
      tick(1);
      scan_en = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         tick(1);
         if (scan_ovr) seen = 1'b1;
      end
      chk("t5_ovr_set", seen, 1);
      scan_en = 1'b0;
      tick(1);
      chk("t5_ovr_clr", scan_ovr, 0);
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         if (scan_valid) seen = 1'b1;
         else tick(1);
      end
      chk("t5_inflight", seen, 1);
      chk("t5_chan", scan_chan, 0);
      tick(30);
      chk("t5_no_rescan", busy, 0);

      // 3: simultaneous CPU and scan demand after reset -> alternate, CPU first
      reset = 1'b1;
      tick(2);
      scan_period = 16'd2; scan_mask = 4'b0001; cpu_src = 2'd3; done_delay = 5;
      scan_en = 1'b1; reset = 1'b0;
      tick(1);
      cpu_req = 1'b1;
      nv = 0;
      for (int c = 0; c < 500 && nv < 4; c++) begin
         tick(1);
         if (cpu_ack) begin kind[nv] = 0; nv++; end
         else if (scan_valid) begin kind[nv] = 1; nv++; end
      end
      cpu_req = 1'b0; scan_en = 1'b0;
      chk("t3_events", nv, 4);
      chk("t3_grant0", kind[0], 0);
      chk("t3_grant1", kind[1], 1);
      chk("t3_grant2", kind[2], 0);
      chk("t3_grant3", kind[3], 1);
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         tick(1);
         if (!busy) seen = 1'b1;
      end
      chk("t3_drain", seen, 1);
      tick(3);

      // 6: reset while waiting for done
      done_delay = 0; cpu_src = 2'd0; cpu_req = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         tick(1);
         if (adc_convert) seen = 1'b1;
      end
      chk("t6_conv_seen", seen, 1);
      tick(5);
      reset = 1'b1;
      tick(1);
      chk("t6_busy", busy, 0);
      chk("t6_ena", adc_ena, 0);
      chk("t6_convert", adc_convert, 0);
      cpu_req = 1'b0;
      acks_in_reset = 0;
      for (int c = 0; c < 3; c++) begin
         tick(1);
         if (cpu_ack) acks_in_reset++;
      end
      reset = 1'b0;
      tick(2);
      if (cpu_ack) acks_in_reset++;
      chk("t6_no_ack", acks_in_reset, 0);
      model_data = 10'h3C3; done_delay = 10;
      cpu_job(2'd3, 200, t_ena, t_conv, t_ack, nconv, src_conv, got_data, got_err);
      chk("t6_ack_seen", t_ack >= 0, 1);
      chk("t6_settle",   t_conv - t_ena, 16);
      chk("t6_latency",  t_ack - t_conv, 15);
      chk("t6_src",      src_conv, 3);
      chk("t6_data",     got_data, 10'h3C3);
      chk("t6_err",      got_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
